// File: rtl/mem_arbiter.sv
// Two-master arbiter (m0 = core LSU, m1 = DMA/debug) onto one single-outstanding memory port, with a response timeout.
// Grant is combinational in IDLE, the completion pulse arrives one cycle after mem_rvalid; a master waits until IDLE (MEM_ARB_FIXED_PRIO_EN: m0 always wins ties).
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    // The counter starts at 0 on the first REQ cycle, so the completion lands exactly TIMEOUT cycles after mem_req rises.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  tmo_cnt;
    logic        owner;
    logic        last_owner;
    logic        pick;
    logic        grant;
    logic        tmo_hit;
    logic        done;
    logic        done_err;
    logic [31:0] done_data;

    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick = !m0_req;
`else
        pick = (m0_req && m1_req) ? !last_owner : m1_req;
`endif
        grant  = rstn && (state == S_IDLE) && (m0_req || m1_req);
        m0_gnt = grant && !pick;
        m1_gnt = grant && pick;
    end

    assign mem_req = (state == S_REQ);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // A real response in the final RESP cycle beats the timeout.
    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = mem_rdata;
        case (state)
            S_REQ: begin
                if (tmo_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    done = 1'b1;
                end else if (tmo_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: ;
        endcase
        if (done_err) begin
            done_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            m0_rvalid  <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rvalid  <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            if (done) begin
                if (owner) begin
                    m1_rvalid <= 1'b1;
                    m1_err    <= done_err;
                    m1_rdata  <= done_data;
                end else begin
                    m0_rvalid <= 1'b1;
                    m0_err    <= done_err;
                    m0_rdata  <= done_data;
                end
            end
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner      <= pick;
                        last_owner <= pick;
                        mem_we     <= pick ? m1_we    : m0_we;
                        mem_addr   <= pick ? m1_addr  : m0_addr;
                        mem_wdata  <= pick ? m1_wdata : m0_wdata;
                        mem_be     <= pick ? m1_be    : m0_be;
                        tmo_cnt    <= '0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (done) begin
                        state <= S_IDLE;
                    end else if (mem_gnt) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (TIMEOUT=8): arbitration vector table, directed corner sequences, and a random run against a transaction-timing model.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, {m0_gnt, m1_gnt}, 0);
        chk({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
        chk({tag, "_err"}, {m0_err, m1_err}, 0);
        chk({tag, "_rdata0"}, m0_rdata, 0);
        chk({tag, "_rdata1"}, m1_rdata, 0);
        chk({tag, "_mem_ctl"}, {mem_req, mem_we, mem_be}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic reset_dut();
        tick();
        rstn = 1'b0; m0_req = 1; m1_req = 1; mem_gnt = 0; mem_rvalid = 0;
        tick();
        tick();
        #1;
        check_all_zero("reset");
        m0_req = 0; m1_req = 0; rstn = 1'b1;
    endtask

    // One full transaction: request cycle, gd wait cycles before mem_gnt, rd before mem_rvalid.
    task automatic do_txn(input bit r0, input bit r1, input int exp_own, input bit we,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] wd0, input logic [31:0] wd1, input logic [3:0] be,
                          input int gd, input int rd, input logic [31:0] rdat);
        logic [31:0] ea, ew;
        tick();
        m0_req = r0; m1_req = r1; m0_we = we; m1_we = we;
        m0_addr = a0; m1_addr = a1; m0_wdata = wd0; m1_wdata = wd1; m0_be = be; m1_be = be;
        mem_gnt = 0; mem_rvalid = 0;
        #1;
        chk("txn_gnt0", m0_gnt, exp_own == 0);
        chk("txn_gnt1", m1_gnt, exp_own == 1);
        if (exp_own == 2) begin
            tick();
            m0_req = 0; m1_req = 0;
            #1;
            chk("txn_idle_mem_req", mem_req, 0);
        end else begin
            ea = (exp_own == 1) ? a1 : a0;
            ew = (exp_own == 1) ? wd1 : wd0;
            for (int k = 0; k <= gd; k++) begin
                tick();
                m0_req = 0; m1_req = 0; m0_addr = $urandom; m1_addr = $urandom;
                mem_gnt = (k == gd);
                #1;
                chk("txn_mem_req", mem_req, 1);
                chk("txn_mem_addr", mem_addr, ea);
                chk("txn_mem_wdata", mem_wdata, ew);
                chk("txn_mem_we_be", {mem_we, mem_be}, {we, be});
            end
            for (int k = 0; k <= rd; k++) begin
                tick();
                mem_gnt = 0; mem_rvalid = (k == rd);
                mem_rdata = (k == rd) ? rdat : $urandom;
                #1;
                chk("txn_resp_mem_req", mem_req, 0);
                chk("txn_early_rvalid", {m0_rvalid, m1_rvalid}, 0);
            end
            tick();
            mem_rvalid = 0;
            #1;
            chk("txn_rvalid0", m0_rvalid, exp_own == 0);
            chk("txn_rvalid1", m1_rvalid, exp_own == 1);
            chk("txn_err", {m0_err, m1_err}, 0);
            if (!we) chk("txn_rdata", (exp_own == 1) ? m1_rdata : m0_rdata, rdat);
        end
    endtask

    // mem_req rises at k=1; the error completion must appear at k=9 (TIMEOUT=8).
    task automatic tmo_seq(input bit give_gnt);
        tick();
        m0_req = 1; m1_req = 0; m0_we = 0; m0_addr = 32'h500;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("tmo_gnt", m0_gnt, 1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            m0_req = 0;
            mem_gnt = give_gnt && (k == 1);
            mem_rvalid = (k >= 10);
            #1;
            chk("tmo_mem_req", mem_req, give_gnt ? (k == 1) : (k <= 8));
            chk("tmo_rvalid0", m0_rvalid, k == 9);
            chk("tmo_err0", m0_err, k == 9);
            chk("tmo_m1_quiet", {m1_rvalid, m1_err}, 0);
            if (k == 9) chk("tmo_rdata0", m0_rdata, 0);
        end
        mem_rvalid = 0;
    endtask

    typedef struct {
        bit          r0;
        bit          r1;
        int          own_rr;
        int          own_fx;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl[8];

    // Random-run model state: transaction windows derived from the grant cycle and chosen delays.
    bit          active, last, done_now, in_req, in_resp, r0, r1, free, t_we, done_own;
    int          t_acc, t_done, t_rv, g, r, win;
    logic [31:0] t_addr, t_wdata, exp_data, done_data;
    logic [3:0]  t_be;

    initial begin
        tbl[0] = '{1, 1, 0, 0, 32'h1111_0000};
        tbl[1] = '{1, 1, 1, 0, 32'h2222_0001};
        tbl[2] = '{1, 0, 0, 0, 32'h3333_0002};
        tbl[3] = '{1, 1, 1, 0, 32'h4444_0003};
        tbl[4] = '{0, 1, 1, 1, 32'h5555_0004};
        tbl[5] = '{1, 1, 0, 0, 32'h6666_0005};
        tbl[6] = '{0, 0, 2, 2, 32'h7777_0006};
        tbl[7] = '{1, 1, 1, 0, 32'h8888_0007};

        reset_dut();
        do_txn(1, 1, 0, 0, 32'h100, 32'h200, 0, 0, 4'hF, 0, 0, 32'hAAAA5555);
        do_txn(1, 1, FIXED ? 0 : 1, 0, 32'h100, 32'h200, 0, 0, 4'hF, 0, 0, 32'h0BAD_F00D);
        for (int i = 0; i < 8; i++)
            do_txn(tbl[i].r0, tbl[i].r1, FIXED ? tbl[i].own_fx : tbl[i].own_rr, 0,
                   32'h1000 + i, 32'h2000 + i, 0, 0, 4'hF, i % 3, (i + 1) % 3, tbl[i].rdat);

        do_txn(0, 1, 1, 1, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF, 4'b0011, 3, 1, 32'h0);

        // Both masters held high: a grant every third cycle, alternating unless fixed priority.
        reset_dut();
        for (int c = 0; c <= 12; c++) begin
            tick();
            m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = c;
            #1;
            chk("b2b_gnt0", m0_gnt, (c % 3 == 0) && (FIXED || ((c / 3) % 2 == 0)));
            chk("b2b_gnt1", m1_gnt, (c % 3 == 0) && !FIXED && ((c / 3) % 2 == 1));
            chk("b2b_rvalid0", m0_rvalid, (c % 3 == 0) && c > 0 && (FIXED || (((c / 3) - 1) % 2 == 0)));
            chk("b2b_rvalid1", m1_rvalid, (c % 3 == 0) && c > 0 && !FIXED && (((c / 3) - 1) % 2 == 1));
            if (c % 3 == 0 && c > 0) chk("b2b_rdata", m0_rvalid ? m0_rdata : m1_rdata, c - 1);
        end
        m0_req = 0; m1_req = 0; mem_gnt = 0; mem_rvalid = 0;
        tick();
        tick();

        tmo_seq(1);
        tmo_seq(0);

        // Reset while in RESP, with mem_rvalid present on that same edge.
        tick();
        m0_req = 1; m1_req = 0; m0_we = 0; m0_addr = 32'h300;
        #1;
        chk("rst_resp_gnt", m0_gnt, 1);
        tick();
        m0_req = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; rstn = 0;
        tick();
        rstn = 1; mem_rvalid = 0;
        #1;
        check_all_zero("rst_resp");
        tick();
        #1;
        chk("rst_resp_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        do_txn(1, 1, 0, 0, 32'h600, 32'h700, 0, 0, 4'h1, 1, 0, 32'hCAFE_0001);

        // Random traffic against the timing model.
        reset_dut();
        active = 0; last = 1; t_done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            r0 = ($urandom_range(0, 99) < 55);
            r1 = ($urandom_range(0, 99) < 55);
            m0_req = r0; m1_req = r1;
            m0_we = $urandom; m1_we = $urandom;
            m0_addr = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            m0_be = 4'($urandom); m1_be = 4'($urandom);

            done_now = active && (cyc == t_done);
            done_own = (win == 1);
            done_data = exp_data;
            free = !active || (cyc >= t_done);
            win = done_now ? win : win;
            if (free && (r0 || r1)) begin
                if (r0 && r1) win = FIXED ? 0 : (last ? 0 : 1);
                else win = r1 ? 1 : 0;
                active = 1; t_acc = cyc; last = (win == 1);
                g = $urandom_range(0, 2); r = $urandom_range(0, 2);
                t_rv = t_acc + 2 + g + r; t_done = t_rv + 1;
                t_we = (win == 1) ? m1_we : m0_we;
                t_addr = (win == 1) ? m1_addr : m0_addr;
                t_wdata = (win == 1) ? m1_wdata : m0_wdata;
                t_be = (win == 1) ? m1_be : m0_be;
            end
            in_req = active && (cyc >= t_acc + 1) && (cyc <= t_acc + 1 + g);
            in_resp = active && (cyc >= t_acc + 2 + g) && (cyc <= t_rv);
            mem_gnt = in_req ? (cyc == t_acc + 1 + g) : ($urandom_range(0, 3) == 0);
            mem_rvalid = in_resp ? (cyc == t_rv) : ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            if (cyc == t_rv) exp_data = mem_rdata;
            #1;
            chk("rnd_gnt0", m0_gnt, free && (r0 || r1) && (win == 0));
            chk("rnd_gnt1", m1_gnt, free && (r0 || r1) && (win == 1));
            chk("rnd_mem_req", mem_req, in_req);
            if (in_req) begin
                chk("rnd_mem_addr", mem_addr, t_addr);
                chk("rnd_mem_wdata", mem_wdata, t_wdata);
                chk("rnd_mem_we_be", {mem_we, mem_be}, {t_we, t_be});
            end
            chk("rnd_rvalid0", m0_rvalid, done_now && !done_own);
            chk("rnd_rvalid1", m1_rvalid, done_now && done_own);
            chk("rnd_err", {m0_err, m1_err}, 0);
            if (done_now) chk("rnd_rdata", done_own ? m1_rdata : m0_rdata, done_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Wall-clock guard so a stuck run still reports.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the cycles allowed from mem_req assertion to mem_rvalid before an error completion; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 m0_req, m1_req  input  1 each  SHALL be the requester access strobes; m0 = core LSU, m1 = DMA/debug.
REQ-005 m0_we, m1_we  input  1 each  SHALL be the write enables: 1 = store, 0 = load.
REQ-006 m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  SHALL be the byte address and the store data.
REQ-007 m0_be, m1_be  input  4 each  SHALL be the byte-lane enables.
REQ-008 m0_gnt, m1_gnt  output  1 each  SHALL pulse for one cycle when the request is accepted.
REQ-009 m0_rvalid, m1_rvalid  output  1 each  SHALL pulse for one cycle on completion.
REQ-010 m0_rdata, m1_rdata  output  32 each  SHALL carry load data, valid while the matching rvalid is high.
REQ-011 m0_err, m1_err  output  1 each  SHALL flag a timed-out completion, valid while the matching rvalid is high.
REQ-012 mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; mem_be  output  4  SHALL form the memory-side request.
REQ-013 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  SHALL form the memory-side handshake and response.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ, RESP. At most one transaction is outstanding.
REQ-015 In IDLE, if any mN_req is high, mN_gnt SHALL go high combinationally for the winner in that cycle only; the winner's we/addr/wdata/be and the owner ID SHALL be latched at the edge; next state is REQ.
REQ-016 Arbitration is round-robin: on simultaneous requests, the winner is the requester that did not own the previous transaction. A lone request always wins.
REQ-017 In REQ: mem_req=1 with the latched payload, held stable until mem_gnt=1; on mem_gnt the next state is RESP.
REQ-018 In RESP: on mem_rvalid=1, mem_rdata SHALL be registered into the owner's mN_rdata; mN_rvalid=1 and mN_err=0 in the following cycle; the next state is IDLE.
REQ-019 Loads and stores both complete only through mem_rvalid. Store rdata is don't-care.
REQ-020 Latency: a request accepted at cycle T gives mem_req at T+1; with mem_gnt at T+1 and mem_rvalid at T+2, owner rvalid is at T+3. In that same T+3 cycle the FSM is in IDLE and can grant the next request (back-to-back throughput of 1 per 3 cycles minimum).
REQ-021 An 8-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ and RESP. On reaching TIMEOUT: next state is IDLE, mem_req drops, owner rvalid=1 and err=1 with rdata=0 in the next cycle.
REQ-022 mem_gnt outside REQ and mem_rvalid outside RESP SHALL be ignored, including a late rvalid after a timeout.
REQ-023 The non-granted requester's gnt, rvalid and err SHALL stay 0. mN_req may drop after gnt without effect.
REQ-024 Outside REQ, mem_req=0, and mem_we/mem_addr/mem_wdata/mem_be hold their last latched values.

Reset
REQ-025 While rstn=0 at an edge: state=IDLE, timeout counter=0, and last owner=m1 (so m0 wins the first contest).
REQ-026 While rstn=0 at an edge, all outputs SHALL be 0 (mem_* payload, rdata, gnt, rvalid, err).
REQ-027 Reset during REQ or RESP SHALL abandon the transaction with no completion reported to either requester.

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-029 With MEM_ARB_FIXED_PRIO_EN defined, m0 SHALL always win simultaneous requests.
REQ-030 Without MEM_ARB_FIXED_PRIO_EN, round-robin per REQ-016 applies. All other behaviour is identical in both builds.

Verification
REQ-031 After reset, m0 load addr=0x100 and m1 load addr=0x200 both asserted; mem_gnt immediate; rdata=0xAAAA5555 -> m0 granted first and m0_rdata=0xAAAA5555; then m1 granted, with mem_addr=0x200.
REQ-032 Both requesters held high for 4 transactions -> grants alternate m0,m1,m0,m1 (with MEM_ARB_FIXED_PRIO_EN defined: m0 four times).
REQ-033 m1 store addr=0x40, wdata=0xDEADBEEF, be=4'b0011, with mem_gnt delayed 3 cycles -> mem_req and payload stable for 4 cycles; m1_rvalid one cycle after mem_rvalid.
REQ-034 TIMEOUT=8, mem_gnt given but mem_rvalid never given -> owner rvalid=1, err=1, rdata=0 exactly 8 cycles after mem_req rose; a stray mem_rvalid afterwards produces no output.
REQ-035 rstn=0 asserted during RESP -> no rvalid on either side; all outputs 0; the next request is handled normally from IDLE.
